// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl
// Issue-stage hazard controller for an in-order pipeline. It tracks the
// instructions in the DEPTH stages after issue, selects operand forwarding
// paths, stalls fetch on a load-use hazard, squashes the branch shadow and
// requests the boot PC load after reset.
//
// Ports
//   clk, rst                 clock; synchronous active-high reset
//   freeze                   hold all internal state for the cycle
//   issue_valid              instruction presented for issue
//   issue_wr, issue_is_load  instruction writes rd / instruction is a load
//   issue_rd/rn/rm/rs        destination and source register indices
//   use_rn/rm/rs             source is actually read
//   branch_taken             taken branch resolved for the entry-0 instruction
//   issue_ready              instruction accepted this cycle
//   stall_pc                 load-use hazard, fetch must hold
//   squash                   presented instruction is discarded
//   load_pc                  boot PC load request
//   fwd_rn/rm/rs             0 = register file, k = result of entry k-1
//   stage_valid              valid bit per tracked entry
module pipe_hazard_ctrl #(
    parameter int DEPTH       = 5,
    parameter int REG_BITS    = 4,
    parameter int LOAD_LAT    = 2,
    parameter int BOOT_CYCLES = 1,
    parameter int SHADOW      = 2,
    localparam int FW         = $clog2(DEPTH + 1)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                freeze,
    input  logic                issue_valid,
    input  logic                issue_wr,
    input  logic                issue_is_load,
    input  logic [REG_BITS-1:0] issue_rd,
    input  logic [REG_BITS-1:0] issue_rn,
    input  logic [REG_BITS-1:0] issue_rm,
    input  logic [REG_BITS-1:0] issue_rs,
    input  logic                use_rn,
    input  logic                use_rm,
    input  logic                use_rs,
    input  logic                branch_taken,
    output logic                issue_ready,
    output logic                stall_pc,
    output logic                squash,
    output logic                load_pc,
    output logic [FW-1:0]       fwd_rn,
    output logic [FW-1:0]       fwd_rm,
    output logic [FW-1:0]       fwd_rs,
    output logic [DEPTH-1:0]    stage_valid
);

    localparam int SW = (SHADOW < 1) ? 1 : $clog2(SHADOW + 1);
    localparam int BW = (BOOT_CYCLES < 2) ? 1 : $clog2(BOOT_CYCLES);

    typedef enum logic {BOOT, RUN} state_t;

    state_t              state, state_nxt;
    logic [BW-1:0]       boot_cnt, boot_nxt;
    logic [SW-1:0]       shadow_cnt;

    // Tracked entries: valid is control (reset), the rest is data (not reset).
    logic [DEPTH-1:0]    vld;
    logic [DEPTH-1:0]    wr;
    logic [DEPTH-1:0]    ld;
    logic [REG_BITS-1:0] rd [DEPTH];

    logic                hit_rn, hit_rm, hit_rs;
    logic                ld_rn, ld_rm, ld_rs;
    logic [FW-1:0]       idx_rn, idx_rm, idx_rs;
    logic                haz_rn, haz_rm, haz_rs, hazard;
    logic                counted_branch, squash_int, ready_int, insert;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= BOOT;
            boot_cnt   <= '0;
            shadow_cnt <= '0;
            vld        <= '0;
        end else if (!freeze) begin
            state    <= state_nxt;
            boot_cnt <= boot_nxt;
            if (counted_branch) begin
                shadow_cnt <= SW'(SHADOW);
            end else if (shadow_cnt != '0) begin
                shadow_cnt <= shadow_cnt - SW'(1);
            end
            vld <= {vld[DEPTH-2:0], insert};
        end
    end

    always_ff @(posedge clk) begin
        if (!freeze) begin
            for (int i = DEPTH - 1; i > 0; i--) begin
                rd[i] <= rd[i-1];
            end
            rd[0] <= issue_rd;
            wr    <= {wr[DEPTH-2:0], issue_wr};
            ld    <= {ld[DEPTH-2:0], issue_is_load};
        end
    end

    always_comb begin
        state_nxt = state;
        boot_nxt  = boot_cnt;
        if (state == BOOT) begin
            if (boot_cnt == BW'(BOOT_CYCLES - 1)) begin
                state_nxt = RUN;
            end else begin
                boot_nxt = boot_cnt + BW'(1);
            end
        end

        // Scan oldest to youngest so the youngest matching writer wins.
        hit_rn = 1'b0; ld_rn = 1'b0; idx_rn = '0;
        hit_rm = 1'b0; ld_rm = 1'b0; idx_rm = '0;
        hit_rs = 1'b0; ld_rs = 1'b0; idx_rs = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (vld[i] && wr[i]) begin
                if (rd[i] == issue_rn) begin hit_rn = 1'b1; ld_rn = ld[i]; idx_rn = FW'(i); end
                if (rd[i] == issue_rm) begin hit_rm = 1'b1; ld_rm = ld[i]; idx_rm = FW'(i); end
                if (rd[i] == issue_rs) begin hit_rs = 1'b1; ld_rs = ld[i]; idx_rs = FW'(i); end
            end
        end

        // A load is not forwardable until it reaches entry LOAD_LAT.
        haz_rn = use_rn && hit_rn && ld_rn && (idx_rn < FW'(LOAD_LAT));
        haz_rm = use_rm && hit_rm && ld_rm && (idx_rm < FW'(LOAD_LAT));
        haz_rs = use_rs && hit_rs && ld_rs && (idx_rs < FW'(LOAD_LAT));
        hazard = haz_rn || haz_rm || haz_rs;

        // Only a real instruction in entry 0 can resolve a branch.
        counted_branch = branch_taken && vld[0] && !freeze && (state == RUN);
        squash_int     = (shadow_cnt != '0) || counted_branch;
        ready_int      = (state == RUN) && !freeze && (squash_int || !hazard);
        insert         = issue_valid && ready_int && !squash_int;

        issue_ready = 1'b0;
        stall_pc    = 1'b0;
        squash      = 1'b0;
        load_pc     = 1'b1;
        fwd_rn      = '0;
        fwd_rm      = '0;
        fwd_rs      = '0;
        stage_valid = '0;
        if (!rst) begin
            issue_ready = ready_int;
            stall_pc    = hazard && !squash_int;
            squash      = squash_int;
            load_pc     = (state == BOOT);
            fwd_rn      = (use_rn && hit_rn && !haz_rn) ? idx_rn + FW'(1) : '0;
            fwd_rm      = (use_rm && hit_rm && !haz_rm) ? idx_rm + FW'(1) : '0;
            fwd_rs      = (use_rs && hit_rs && !haz_rs) ? idx_rs + FW'(1) : '0;
            stage_valid = vld;
        end
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 Parameter DEPTH, default 5, number of tracked stages after issue (entry 0 = stage after issue).
REQ-002 Parameter REG_BITS, default 4, register-index width.
REQ-003 Parameter LOAD_LAT, default 2, first entry index at which a load result is forwardable (1..DEPTH-1).
REQ-004 Parameter BOOT_CYCLES, default 1, cycles load_pc is held after reset.
REQ-005 Parameter SHADOW, default 2, issue slots squashed after a taken branch.
REQ-006 Localparam FW = $clog2(DEPTH+1), forward-select width.
REQ-007 clk  in  1  single clock; all state updates on its rising edge.
REQ-008 rst  in  1  synchronous, active-high reset.
REQ-009 freeze  in  1  holds all internal state for the cycle.
REQ-010 issue_valid  in  1  instruction presented for issue.
REQ-011 issue_wr, issue_is_load  in  1 each  instruction writes rd; instruction is a load.
REQ-012 issue_rd, issue_rn, issue_rm, issue_rs  in  REG_BITS each  destination and source indices.
REQ-013 use_rn, use_rm, use_rs  in  1 each  source is read.
REQ-014 branch_taken  in  1  taken branch resolved for the instruction in entry 0.
REQ-015 issue_ready  out  1  instruction accepted this cycle.
REQ-016 stall_pc  out  1  load-use hazard; fetch must hold.
REQ-017 squash  out  1  presented instruction is discarded (flush).
REQ-018 load_pc  out  1  boot PC load request.
REQ-019 fwd_rn, fwd_rm, fwd_rs  out  FW each  0 = register file, k = entry k-1.
REQ-020 stage_valid  out  DEPTH  valid bit per entry.

Function
REQ-021 States BOOT and RUN; BOOT lasts exactly BOOT_CYCLES cycles, then RUN permanently until rst.
REQ-022 In BOOT: load_pc=1, issue_ready=0, no entry insertion; in RUN: load_pc=0.
REQ-023 Each entry holds {valid, wr, rd, is_load}; unless freeze, entry[i] <= entry[i-1] for i>=1 every cycle.
REQ-024 Entry 0 loads the issued instruction when issue_valid & issue_ready & !squash, otherwise a bubble (valid=0).
REQ-025 Match for a used source: lowest-index entry with valid & wr & rd==source; entries without a match give fwd=0.
REQ-026 fwd_x = match index + 1 when matched and not a load-use hazard; fwd_x=0 when use_x=0.
REQ-027 Load-use hazard: matched entry has is_load=1 and index < LOAD_LAT; then stall_pc=1, issue_ready=0, fwd values don't-care.
REQ-028 Hazard evaluation is combinational against current entries; stall repeats until the load reaches entry LOAD_LAT.
REQ-029 branch_taken counts only when entry[0].valid=1; otherwise ignored.
REQ-030 On counted branch_taken: squash=1 and issue_ready=1 this cycle, shadow counter <= SHADOW.
REQ-031 While counter > 0: squash=1, issue_ready=1, counter decrements by 1 per non-frozen cycle; no insertion.
REQ-032 Squash outranks stall: stall_pc=0 whenever squash=1.
REQ-033 freeze=1: no shift, no counter change, no state change; combinational outputs still reflect held state; issue_ready=0.
REQ-034 freeze outranks branch_taken; a branch_taken during freeze is not counted.

Reset
REQ-035 rst=1 clears all entries, shadow counter=0, state=BOOT with boot counter reloaded, regardless of freeze.
REQ-036 During rst and the first BOOT cycle after it: issue_ready=0, stall_pc=0, squash=0, fwd_*=0, stage_valid=0, load_pc=1.
REQ-037 rst mid-flush or mid-stall abandons that operation; no squash or stall persists past reset.

Verification (DEPTH=5, LOAD_LAT=2, BOOT_CYCLES=1, SHADOW=2)
REQ-038 Release rst -> load_pc=1 for exactly 1 cycle, then issue_ready=1 with issue_valid=1.
REQ-039 Issue ADD r3 (wr), next ADD reads r3 via rn -> fwd_rn=1; one bubble between them -> fwd_rn=2.
REQ-040 Issue LDR r2, next instruction uses r2 via rm -> stall_pc=1 for 2 cycles, then fwd_rm=3, issue_ready=1.
REQ-041 Older r4 writer in entry 3 and younger r4 writer in entry 1, source r4 used -> fwd=2 (youngest wins).
REQ-042 branch_taken with entry[0] valid -> squash=1 for 3 consecutive cycles, stage_valid[0]=0 for those slots; simultaneous load-use -> stall_pc=0.
REQ-043 freeze=1 for 3 cycles mid-flush, then rst=1 -> stage_valid unchanged during freeze; after rst all outputs equal REQ-036 values.
